vdp_host_master: RTL and testbench

- Host-side bus initiator for the TMS9918A-compatible VDP's two I/O ports (VRAM data port, control/status port).
- Converts simple commands into correctly sequenced port cycles on the VDP CPU bus: register writes, VRAM write bursts, VRAM read bursts, status reads.
- Sits in place of a Z80 for testbenches, or beside one as a block loader. It drives cpu_a/cpu_din/cpu_out_n/cpu_in_n of the VDP and samples cpu_dout.

---
 rtl/vdp_host_master_if.sv | 38 +++
 rtl/vdp_host_master.sv | 207 ++++++++++++++++++++
 tb/tb_vdp_host_master.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vdp_host_master_if.sv
`timescale 1ns/1ps
// Command, byte-stream and VDP CPU-bus signals of the host master, grouped so
// the master and its environment share one bundle.
interface vdp_host_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [13:0] cmd_addr;
  logic [13:0] cmd_len;
  logic [7:0]  cmd_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [7:0]  rd_data;
  logic [7:0]  io_a;
  logic [7:0]  io_dout;
  logic [7:0]  io_din;
  logic        io_out_n;
  logic        io_in_n;
  logic        busy;
  logic        done;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data,
    input  wr_valid, wr_data, rd_ready, io_din,
    output cmd_ready, wr_ready, rd_valid, rd_data,
    output io_a, io_dout, io_out_n, io_in_n, busy, done
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data,
    output wr_valid, wr_data, rd_ready, io_din,
    input  cmd_ready, wr_ready, rd_valid, rd_data,
    input  io_a, io_dout, io_out_n, io_in_n, busy, done
  );
endinterface

// File: rtl/vdp_host_master.sv
`timescale 1ns/1ps
// Host-side initiator for the VDP CPU bus: turns register, VRAM and status
// commands into strobed I/O cycles on the VDP data and control ports.
module vdp_host_master #(
  parameter logic [7:0] VRAM_PORT     = 8'h01,
  parameter logic [7:0] VDP_PORT      = 8'h02,
  parameter int         STROBE_CYCLES = 4,
  parameter int         GAP_CYCLES    = 2
) (
  input logic               clk40m,
  input logic               rst,
  vdp_host_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_WR, S_WAIT_RD, S_SETUP, S_STROBE, S_HOLD, S_GAP, S_DONE
  } state_t;

  typedef enum logic [1:0] {SEQ_CTRL0, SEQ_CTRL1, SEQ_DATA} seq_t;

  state_t      state_q, state_d;
  seq_t        seq_q, seq_d;
  logic [1:0]  op_q, op_d;
  logic [13:0] addr_q, addr_d;
  logic [13:0] len_q, len_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] cnt_q, cnt_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        wr_ready_q, wr_ready_d;
  logic        rd_valid_q, rd_valid_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic [7:0]  io_a_q, io_a_d;
  logic [7:0]  io_dout_q, io_dout_d;
  logic        io_out_n_q, io_out_n_d;
  logic        io_in_n_q, io_in_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        advance;
  logic        rd_cycle;

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    op_d       = op_q;
    addr_d     = addr_q;
    len_d      = len_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    io_a_d     = io_a_q;
    io_dout_d  = io_dout_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q && !bus.rd_ready;
    advance    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d   = bus.cmd_op;
          addr_d = bus.cmd_addr;
          len_d  = bus.cmd_len;
          data_d = bus.cmd_data;
          if (bus.cmd_op == 2'b11) begin
            seq_d   = SEQ_DATA;
            state_d = rd_valid_d ? S_WAIT_RD : S_SETUP;
          end else begin
            seq_d   = SEQ_CTRL0;
            state_d = S_SETUP;
          end
        end
      end
      S_WAIT_WR: begin
        if (bus.wr_valid) begin
          state_d = S_SETUP;
          len_d   = len_q - 14'd1;
        end
      end
      S_WAIT_RD: begin
        if (!rd_valid_d) begin
          state_d = S_SETUP;
          if (op_q == 2'b10) len_d = len_q - 14'd1;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = '0;
      end
      S_STROBE: begin
        if (cnt_q == 16'(STROBE_CYCLES - 1)) begin
          state_d = S_HOLD;
          if (seq_q == SEQ_DATA && op_q[1]) begin
            rd_data_d  = bus.io_din;
            rd_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_HOLD: begin
        if (GAP_CYCLES == 0) begin
          advance = 1'b1;
        end else begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (cnt_q == 16'(GAP_CYCLES - 1)) advance = 1'b1;
        else cnt_d = cnt_q + 16'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pick the next byte once a bus cycle has fully retired.
    if (advance) begin
      if (seq_q == SEQ_CTRL0) begin
        seq_d   = SEQ_CTRL1;
        state_d = S_SETUP;
      end else if (op_q == 2'b00 || op_q == 2'b11 || len_q == 14'd0) begin
        state_d = S_DONE;
      end else begin
        seq_d = SEQ_DATA;
        if (op_q == 2'b01) begin
          state_d = S_WAIT_WR;
        end else if (rd_valid_d) begin
          state_d = S_WAIT_RD;
        end else begin
          state_d = S_SETUP;
          len_d   = len_q - 14'd1;
        end
      end
    end

    if (state_d == S_SETUP) begin
      io_a_d = VDP_PORT;
      unique case (seq_d)
        SEQ_CTRL0: io_dout_d = (op_d == 2'b00) ? data_d : addr_d[7:0];
        SEQ_CTRL1: io_dout_d = (op_d == 2'b00) ? {5'b10000, addr_d[2:0]}
                                               : {1'b0, (op_d == 2'b01), addr_d[13:8]};
        default: begin
          io_a_d    = (op_d == 2'b11) ? VDP_PORT : VRAM_PORT;
          io_dout_d = (op_d == 2'b01) ? bus.wr_data : 8'h00;
        end
      endcase
    end

    rd_cycle    = (seq_d == SEQ_DATA) && op_d[1];
    io_out_n_d  = !((state_d == S_STROBE) && !rd_cycle);
    io_in_n_d   = !((state_d == S_STROBE) && rd_cycle);
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    wr_ready_d  = (state_d == S_WAIT_WR);
  end

  always_ff @(posedge clk40m or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      seq_q       <= SEQ_CTRL0;
      op_q        <= 2'b00;
      addr_q      <= '0;
      len_q       <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      io_a_q      <= '0;
      io_dout_q   <= '0;
      io_out_n_q  <= 1'b1;
      io_in_n_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      io_a_q      <= io_a_d;
      io_dout_q   <= io_dout_d;
      io_out_n_q  <= io_out_n_d;
      io_in_n_q   <= io_in_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.wr_ready  = wr_ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.io_a      = io_a_q;
  assign bus.io_dout   = io_dout_q;
  assign bus.io_out_n  = io_out_n_q;
  assign bus.io_in_n   = io_in_n_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_vdp_host_master.sv
`timescale 1ns/1ps
// Directed bench for vdp_host_master: a table of commands checked against a
// log of observed bus cycles, plus hand sequences for timing, stall and reset.
module tb_vdp_host_master;
  logic clk40m = 1'b0;
  logic rst    = 1'b0;
  int   cyc    = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  vdp_host_master_if bus();

  vdp_host_master dut (
    .clk40m (clk40m),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk40m = ~clk40m;
  always @(posedge clk40m) cyc <= cyc + 1;

  // Stand-in for the VDP and the byte producer: one byte per handshake / read strobe.
  logic [0:3][7:0] wmodel, rmodel;
  logic [1:0]      wr_idx, rd_idx;
  logic            in_prev;

  always @(posedge clk40m or posedge rst) begin
    if (rst) begin
      wr_idx  <= '0;
      rd_idx  <= '0;
      in_prev <= 1'b1;
    end else begin
      in_prev <= bus.io_in_n;
      if (bus.wr_valid && bus.wr_ready) wr_idx <= wr_idx + 2'd1;
      if (!in_prev && bus.io_in_n) rd_idx <= rd_idx + 2'd1;
    end
  end

  always_comb begin
    bus.wr_data = wmodel[wr_idx];
    bus.io_din  = rmodel[rd_idx];
  end

  logic [0:15]      lw;
  logic [0:15][7:0] la, ld;
  int               ll[16];
  int               log_n, run, done_cnt, wr_pulses, both_low, rd_n;
  logic [0:7][7:0]  rcap;
  logic             wr_prev, cw;
  logic [7:0]       ca, cd;

  always @(negedge clk40m) begin
    if (rst) begin
      log_n <= 0; run <= 0; done_cnt <= 0; wr_pulses <= 0;
      both_low <= 0; rd_n <= 0; wr_prev <= 1'b0;
    end else begin
      if (!bus.io_out_n || !bus.io_in_n) begin
        if (run == 0) begin
          cw <= !bus.io_out_n;
          ca <= bus.io_a;
          cd <= bus.io_dout;
        end
        run <= run + 1;
        if (!bus.io_out_n && !bus.io_in_n) both_low <= both_low + 1;
      end else if (run != 0) begin
        if (log_n < 16) begin
          lw[log_n] <= cw;
          la[log_n] <= ca;
          ld[log_n] <= cd;
          ll[log_n] <= run;
        end
        log_n <= log_n + 1;
        run   <= 0;
      end
      if (bus.wr_ready && !wr_prev) wr_pulses <= wr_pulses + 1;
      wr_prev <= bus.wr_ready;
      if (bus.done) done_cnt <= done_cnt + 1;
      if (bus.rd_valid && bus.rd_ready) begin
        if (rd_n < 8) rcap[rd_n] <= bus.rd_data;
        rd_n <= rd_n + 1;
      end
    end
  end

  typedef struct {
    logic [1:0]      op;
    logic [13:0]     addr;
    logic [13:0]     len;
    logic [7:0]      data;
    logic [0:3][7:0] wb;
    logic [0:3][7:0] rb;
    int              n;
    logic [0:5]      w;
    logic [0:5][7:0] a;
    logic [0:5][7:0] d;
    int              pulses;
    int              nrd;
    logic [0:1][7:0] rexp;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [1:0] op, input logic [13:0] addr, input logic [13:0] len,
                              input logic [7:0] data, input logic [0:3][7:0] wb, input logic [0:3][7:0] rb,
                              input int n, input logic [0:5] w, input logic [0:5][7:0] a,
                              input logic [0:5][7:0] d, input int pulses, input int nrd,
                              input logic [0:1][7:0] rexp);
    vec_t r;
    r.op = op; r.addr = addr; r.len = len; r.data = data; r.wb = wb; r.rb = rb;
    r.n = n; r.w = w; r.a = a; r.d = d; r.pulses = pulses; r.nrd = nrd; r.rexp = rexp;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [13:0] addr, input logic [13:0] len,
                               input logic [7:0] data, output int acc);
    int guard;
    guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 100) begin
      @(posedge clk40m); #1;
      guard++;
    end
    checkOutput("cmd_ready_before_issue", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    acc = cyc;
    @(posedge clk40m); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int at);
    int n;
    n  = 0;
    at = -1;
    while (n < budget) begin
      @(negedge clk40m);
      if (bus.done === 1'b1) begin
        at = cyc;
        break;
      end
      n++;
    end
    @(posedge clk40m); #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk40m); @(posedge clk40m); #1;
    rst = 1'b0;
    @(posedge clk40m); #1;
  endtask

  initial begin
    int acc, at, guard;
    logic found;

    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.cmd_data = '0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
    wmodel = '0; rmodel = '0;

    vecs[0] = mk(2'b00, 14'h0001, 14'd0, 8'hE0, '0, '0, 2, 6'b110000,
                 {8'h02, 8'h02, 32'h0}, {8'hE0, 8'h81, 32'h0}, 0, 0, '0);
    vecs[1] = mk(2'b01, 14'h1800, 14'd3, 8'h00, {8'h11, 8'h22, 8'h33, 8'h44}, '0, 5, 6'b111110,
                 {8'h02, 8'h02, 8'h01, 8'h01, 8'h01, 8'h00}, {8'h00, 8'h58, 8'h11, 8'h22, 8'h33, 8'h00},
                 3, 0, '0);
    vecs[2] = mk(2'b01, 14'h0123, 14'd0, 8'h00, {8'hEE, 8'hEE, 8'hEE, 8'hEE}, '0, 2, 6'b110000,
                 {8'h02, 8'h02, 32'h0}, {8'h23, 8'h41, 32'h0}, 0, 0, '0);
    vecs[3] = mk(2'b11, 14'h0000, 14'd0, 8'h00, '0, {8'h9F, 8'h00, 8'h00, 8'h00}, 1, 6'b000000,
                 {8'h02, 40'h0}, '0, 0, 1, {8'h9F, 8'h00});
    vecs[4] = mk(2'b10, 14'h3FFF, 14'd2, 8'h00, '0, {8'hA5, 8'h5A, 8'h00, 8'h00}, 4, 6'b110000,
                 {8'h02, 8'h02, 8'h01, 8'h01, 16'h0}, {8'hFF, 8'h3F, 32'h0}, 0, 2, {8'hA5, 8'h5A});
    vecs[5] = mk(2'b00, 14'h0007, 14'd0, 8'h5C, '0, '0, 2, 6'b110000,
                 {8'h02, 8'h02, 32'h0}, {8'h5C, 8'h87, 32'h0}, 0, 0, '0);
    vecs[6] = mk(2'b10, 14'h2A55, 14'd0, 8'h00, '0, {8'h77, 8'h00, 8'h00, 8'h00}, 2, 6'b110000,
                 {8'h02, 8'h02, 32'h0}, {8'h55, 8'h2A, 32'h0}, 0, 0, '0);

    #2 rst = 1'b1;
    @(posedge clk40m); @(posedge clk40m); #1;
    checkOutput("rst_io_out_n", 32'(bus.io_out_n), 32'd1);
    checkOutput("rst_io_in_n", 32'(bus.io_in_n), 32'd1);
    checkOutput("rst_io_a", 32'(bus.io_a), 32'h0);
    checkOutput("rst_io_dout", 32'(bus.io_dout), 32'h0);
    checkOutput("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    checkOutput("rst_rd_data", 32'(bus.rd_data), 32'h0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk40m); #1;

    for (int v = 0; v < NV; v++) begin
      doReset();
      wmodel = vecs[v].wb;
      rmodel = vecs[v].rb;
      bus.wr_valid = 1'b1;
      bus.rd_ready = 1'b1;
      applyStimulus(vecs[v].op, vecs[v].addr, vecs[v].len, vecs[v].data, acc);
      waitDone(400, at);
      repeat (3) @(posedge clk40m);
      #1;
      checkOutput($sformatf("v%0d_done_seen", v), 32'(at >= 0), 32'd1);
      checkOutput($sformatf("v%0d_done_count", v), 32'(done_cnt), 32'd1);
      checkOutput($sformatf("v%0d_cycle_count", v), 32'(log_n), 32'(vecs[v].n));
      for (int i = 0; i < vecs[v].n && i < 6; i++) begin
        checkOutput($sformatf("v%0d_c%0d_dir", v, i), 32'(lw[i]), 32'(vecs[v].w[i]));
        checkOutput($sformatf("v%0d_c%0d_port", v, i), 32'(la[i]), 32'(vecs[v].a[i]));
        if (vecs[v].w[i]) checkOutput($sformatf("v%0d_c%0d_data", v, i), 32'(ld[i]), 32'(vecs[v].d[i]));
        checkOutput($sformatf("v%0d_c%0d_strobe_len", v, i), 32'(ll[i]), 32'd4);
      end
      checkOutput($sformatf("v%0d_wr_ready_pulses", v), 32'(wr_pulses), 32'(vecs[v].pulses));
      checkOutput($sformatf("v%0d_both_strobes_low", v), 32'(both_low), 32'd0);
      checkOutput($sformatf("v%0d_read_count", v), 32'(rd_n), 32'(vecs[v].nrd));
      for (int i = 0; i < vecs[v].nrd && i < 2; i++)
        checkOutput($sformatf("v%0d_read%0d", v, i), 32'(rcap[i]), 32'(vecs[v].rexp[i]));
      checkOutput($sformatf("v%0d_idle_after", v), 32'(bus.busy), 32'd0);
    end

    // Register write: exact completion latency, and cmd_valid ignored while busy.
    doReset();
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    applyStimulus(2'b00, 14'h0003, 14'd0, 8'h1E, acc);
    checkOutput("a_busy_next_clock", 32'(bus.busy), 32'd1);
    checkOutput("a_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_op = 2'b11;
    bus.cmd_valid = 1'b1;
    repeat (5) @(posedge clk40m);
    #1;
    bus.cmd_valid = 1'b0;
    waitDone(100, at);
    checkOutput("a_done_latency", 32'(at - acc), 32'd17);
    checkOutput("a_cycle_count", 32'(log_n), 32'd2);
    checkOutput("a_second_byte", 32'(ld[1]), 32'h83);
    checkOutput("a_first_byte", 32'(ld[0]), 32'h1E);
    checkOutput("a_cmd_ready_after", 32'(bus.cmd_ready), 32'd1);

    // VRAM read with the consumer stalled: second in-cycle must wait.
    doReset();
    rmodel = {8'hA5, 8'h5A, 8'h00, 8'h00};
    bus.rd_ready = 1'b0;
    applyStimulus(2'b10, 14'h3FFF, 14'd2, 8'h00, acc);
    repeat (40) @(posedge clk40m);
    #1;
    checkOutput("b_rd_valid_held", 32'(bus.rd_valid), 32'd1);
    checkOutput("b_first_byte", 32'(bus.rd_data), 32'hA5);
    checkOutput("b_cycles_while_stalled", 32'(log_n), 32'd3);
    checkOutput("b_io_in_n_high", 32'(bus.io_in_n), 32'd1);
    checkOutput("b_busy_stalled", 32'(bus.busy), 32'd1);
    bus.rd_ready = 1'b1;
    waitDone(200, at);
    checkOutput("b_done_seen", 32'(at >= 0), 32'd1);
    checkOutput("b_read_count", 32'(rd_n), 32'd2);
    checkOutput("b_read0", 32'(rcap[0]), 32'hA5);
    checkOutput("b_read1", 32'(rcap[1]), 32'h5A);
    checkOutput("b_cycle_count", 32'(log_n), 32'd4);

    // Reset while a VRAM data strobe is low, then a fresh register write.
    doReset();
    wmodel = {8'h11, 8'h22, 8'h33, 8'h44};
    bus.wr_valid = 1'b1;
    applyStimulus(2'b01, 14'h0000, 14'd3, 8'h00, acc);
    found = 1'b0;
    guard = 0;
    while (!found && guard < 300) begin
      @(negedge clk40m);
      if (bus.io_out_n === 1'b0 && bus.io_a === 8'h01) found = 1'b1;
      guard++;
    end
    checkOutput("c_data_strobe_seen", 32'(found), 32'd1);
    @(posedge clk40m); #1;
    rst = 1'b1;
    #1;
    checkOutput("c_io_out_n_released", 32'(bus.io_out_n), 32'd1);
    checkOutput("c_busy_in_reset", 32'(bus.busy), 32'd0);
    checkOutput("c_wr_ready_in_reset", 32'(bus.wr_ready), 32'd0);
    @(posedge clk40m); #1;
    rst = 1'b0;
    bus.wr_valid = 1'b0;
    @(posedge clk40m); #1;
    checkOutput("c_cmd_ready_after", 32'(bus.cmd_ready), 32'd1);
    checkOutput("c_busy_after", 32'(bus.busy), 32'd0);
    applyStimulus(2'b00, 14'h0002, 14'd0, 8'h33, acc);
    waitDone(100, at);
    checkOutput("c_done_latency", 32'(at - acc), 32'd17);
    checkOutput("c_cycle_count", 32'(log_n), 32'd2);
    checkOutput("c_byte0", 32'(ld[0]), 32'h33);
    checkOutput("c_byte1", 32'(ld[1]), 32'h82);
    checkOutput("c_done_count", 32'(done_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
